// File: rtl/bp_update_queue.sv
// Branch-resolution update queue: compacts up to WIDTH resolved branches per cycle
// into a circular FIFO and drains them oldest-first into the predictor write port.
`ifndef BRANCH_HISTORY_REG_SZ
`define BRANCH_HISTORY_REG_SZ 8
`endif

module bp_update_queue #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 8,
  parameter int ADDR      = 32,
  parameter int BHR_DEPTH = `BRANCH_HISTORY_REG_SZ
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           res_valid,
  input  logic [WIDTH-1:0]           res_taken,
  input  logic [WIDTH*ADDR-1:0]      res_pc,
  input  logic [WIDTH*ADDR-1:0]      res_target,
  input  logic [WIDTH*BHR_DEPTH-1:0] res_bhr,
  output logic                       res_ready,
  output logic                       wr_en,
  output logic                       wr_taken,
  output logic [ADDR-1:0]            wr_pc,
  output logic [ADDR-1:0]            wr_target,
  output logic [BHR_DEPTH-1:0]       wr_bhr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                 taken_mem  [DEPTH];
  logic [ADDR-1:0]      pc_mem     [DEPTH];
  logic [ADDR-1:0]      target_mem [DEPTH];
  logic [BHR_DEPTH-1:0] bhr_mem    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] accept_cnt;
  logic [CNT_W-1:0] valid_run;
  logic [PTR_W-1:0] lane_idx [WIDTH];

  // Readiness is judged on registered occupancy only; a same-cycle drain is not credited.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count;
    res_ready  = (free_slots >= CNT_W'(WIDTH));
  end

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    valid_run = '0;
    lane_idx  = '{default: '0};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lane_idx[i] = tail + PTR_W'(valid_run);
      valid_run   = valid_run + CNT_W'(res_valid[i]);
    end
    accept_cnt = res_ready ? valid_run : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset && res_ready) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (res_valid[i]) begin
          taken_mem[lane_idx[i]]  <= res_taken[i];
          pc_mem[lane_idx[i]]     <= res_pc[i*ADDR +: ADDR];
          target_mem[lane_idx[i]] <= res_target[i*ADDR +: ADDR];
          bhr_mem[lane_idx[i]]    <= res_bhr[i*BHR_DEPTH +: BHR_DEPTH];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      if (wr_en) head <= head + PTR_W'(1);
      tail    <= tail + PTR_W'(accept_cnt);
      count   <= count + accept_cnt - CNT_W'(wr_en);
      dropped <= ~res_ready & (|res_valid);
    end
  end

  // Write port reads the head entry directly; zeros are presented while empty.
  always_comb begin
    wr_en     = (count != '0);
    wr_taken  = wr_en ? taken_mem[head]  : 1'b0;
    wr_pc     = wr_en ? pc_mem[head]     : '0;
    wr_target = wr_en ? target_mem[head] : '0;
    wr_bhr    = wr_en ? bhr_mem[head]    : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count <= CNT_W'(DEPTH));
      assert ((head != tail) || (count == '0) || (count == CNT_W'(DEPTH)));
      assert (!$isunknown(wr_en));
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed and randomized bench for bp_update_queue against a queue-based
// reference model of the predictor update stream.
module tb_bp_update_queue;
  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int ADDR  = 32;
  localparam int BHR   = 8;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [WIDTH-1:0]       res_valid;
  logic [WIDTH-1:0]       res_taken;
  logic [WIDTH*ADDR-1:0]  res_pc;
  logic [WIDTH*ADDR-1:0]  res_target;
  logic [WIDTH*BHR-1:0]   res_bhr;
  logic                   res_ready;
  logic                   wr_en;
  logic                   wr_taken;
  logic [ADDR-1:0]        wr_pc;
  logic [ADDR-1:0]        wr_target;
  logic [BHR-1:0]         wr_bhr;
  logic [$clog2(DEPTH):0] count;
  logic                   dropped;

  bp_update_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .BHR_DEPTH(BHR)) dut (
    .clock(clock), .reset(reset),
    .res_valid(res_valid), .res_taken(res_taken), .res_pc(res_pc),
    .res_target(res_target), .res_bhr(res_bhr), .res_ready(res_ready),
    .wr_en(wr_en), .wr_taken(wr_taken), .wr_pc(wr_pc), .wr_target(wr_target),
    .wr_bhr(wr_bhr), .count(count), .dropped(dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            taken;
    logic [ADDR-1:0] pc;
    logic [ADDR-1:0] tgt;
    logic [BHR-1:0]  bhr;
  } ent_t;

  ent_t q[$];
  logic exp_dropped = 1'b0;
  int   compared    = 0;
  int   mismatched  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    h = '{taken: 1'b0, pc: '0, tgt: '0, bhr: '0};
    if (q.size() != 0) h = q[0];
    chk("wr_en",     64'(wr_en),     64'(q.size() != 0));
    chk("count",     64'(count),     64'(q.size()));
    chk("res_ready", 64'(res_ready), 64'((DEPTH - q.size()) >= WIDTH));
    chk("dropped",   64'(dropped),   64'(exp_dropped));
    chk("wr_pc",     64'(wr_pc),     64'(h.pc));
    chk("wr_target", 64'(wr_target), 64'(h.tgt));
    chk("wr_taken",  64'(wr_taken),  64'(h.taken));
    chk("wr_bhr",    64'(wr_bhr),    64'(h.bhr));
  endtask

  // One clock: apply inputs, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input logic rst, input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] tk,
                      input logic [ADDR-1:0] pc0, input logic [ADDR-1:0] pc1,
                      input logic [ADDR-1:0] tg0, input logic [ADDR-1:0] tg1,
                      input logic [BHR-1:0] b0, input logic [BHR-1:0] b1);
    bit   ready;
    ent_t e;
    reset      = rst;
    res_valid  = v;
    res_taken  = tk;
    res_pc     = {pc1, pc0};
    res_target = {tg1, tg0};
    res_bhr    = {b1, b0};
    @(negedge clock);
    check_outputs();
    ready = ((DEPTH - q.size()) >= WIDTH);
    if (rst) begin
      q.delete();
      exp_dropped = 1'b0;
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (ready) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (v[i]) begin
            e.taken = tk[i];
            e.pc    = (i == 0) ? pc0 : pc1;
            e.tgt   = (i == 0) ? tg0 : tg1;
            e.bhr   = (i == 0) ? b0 : b1;
            q.push_back(e);
          end
        end
      end
      exp_dropped = !ready && (v != '0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic rstep(input logic rst, input logic [WIDTH-1:0] v,
                       input logic [ADDR-1:0] pc0, input logic [ADDR-1:0] pc1);
    step(rst, v, WIDTH'($urandom), pc0, pc1, ADDR'($urandom), ADDR'($urandom),
         BHR'($urandom), BHR'($urandom));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; res_valid = '0; res_taken = '0;
    res_pc = '0; res_target = '0; res_bhr = '0;
    repeat (2) @(posedge clock);
    #1;
    step(1'b1, '0, '0, '0, '0, '0, '0, '0, '0);

    // Reset then idle
    repeat (10) idle();

    // Single lane 0 update, visible the following cycle then gone
    step(1'b0, 2'b01, 2'b01, 32'h100, 32'h0, 32'h200, 32'h0, 8'd3, 8'd0);
    chk("t2_wr_en",  64'(wr_en),     64'd1);
    chk("t2_pc",     64'(wr_pc),     64'h100);
    chk("t2_target", 64'(wr_target), 64'h200);
    chk("t2_taken",  64'(wr_taken),  64'd1);
    chk("t2_bhr",    64'(wr_bhr),    64'd3);
    idle();
    chk("t2_empty",  64'(wr_en),     64'd0);
    idle();

    // Lane 1 alone, then both lanes: order 0x40, 0x80, 0x84
    rstep(1'b0, 2'b10, 32'h0, 32'h40);
    chk("t3_pc0", 64'(wr_pc), 64'h40);
    rstep(1'b0, 2'b11, 32'h80, 32'h84);
    chk("t3_pc1", 64'(wr_pc), 64'h80);
    idle();
    chk("t3_pc2", 64'(wr_pc), 64'h84);
    repeat (2) idle();

    // Saturate with two lanes every cycle; readiness drops and lanes are dropped
    for (int i = 0; i < 12; i++) rstep(1'b0, 2'b11, 32'h1000 + 32'(i*8), 32'h1004 + 32'(i*8));
    repeat (10) idle();

    // Wrap-around: single-lane updates interleaved with two-lane bursts
    for (int i = 0; i < 20; i++) begin
      rstep(1'b0, 2'b01, 32'h2000 + 32'(i*4), 32'h0);
      if (i % 3 == 2) rstep(1'b0, 2'b11, 32'h3000 + 32'(i*8), 32'h3004 + 32'(i*8));
    end
    repeat (12) idle();
    chk("t5_drained", 64'(count), 64'd0);

    // Reset with entries queued discards them all
    for (int i = 0; i < 4; i++) rstep(1'b0, 2'b11, 32'h4000 + 32'(i*8), 32'h4004 + 32'(i*8));
    chk("t6_count5", 64'(count), 64'd5);
    step(1'b1, '0, '0, '0, '0, '0, '0, '0, '0);
    chk("t6_count0", 64'(count), 64'd0);
    chk("t6_wr_en",  64'(wr_en), 64'd0);
    rstep(1'b0, 2'b01, 32'h5000, 32'h0);
    chk("t6_fresh", 64'(wr_pc), 64'h5000);
    repeat (3) idle();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      rstep(($urandom_range(0, 99) == 0), WIDTH'($urandom_range(0, 3)), $urandom, $urandom);
    repeat (12) idle();
    chk("final_empty", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
